ls_unit: RTL and testbench

Load/store execution unit; the responder end of the LS-buffer issue interface.
- Accepts one memory op at a time from the LS buffer.
- Drives a single-outstanding request to the memory controller.
- Sign/zero-extends load data and broadcasts load results on the LS CDB.
- Reports busy back to the LS buffer so it never issues while an op is in flight.

---
 rtl/ls_unit.sv | 187 ++++++++++++++++++
 tb/tb_ls_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_unit.sv
// ls_unit: load/store execution unit sitting behind the LS buffer.
//
// Takes one memory op at a time, drives a single-outstanding request to the
// memory controller, extends returned load data and broadcasts it on the LS
// CDB. busy_o tells the LS buffer not to issue while an op is in flight.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; low freezes every register
//   enable_i          one-cycle issue strobe from the LS buffer
//   openum_i          opcode of the issued op
//   addr_i, wdata_i   effective address and store data
//   rob_id_i          ROB id of the issued op (0 = none)
//   busy_o            unit cannot accept an issue this cycle
//   misbranch_i       pipeline flush
//   mem_valid_o/we/addr/wdata/len   request to the memory controller
//   mem_done_i, mem_rdata_i         completion pulse and read data
//   cdb_valid_o, cdb_rob_id_o, cdb_result_o   LS CDB broadcast
module ls_unit #(
    parameter int OPENUM_W = 6,
    parameter int ROB_ID_W = 5,
    parameter logic [OPENUM_W-1:0] OP_LB  = OPENUM_W'(1),
    parameter logic [OPENUM_W-1:0] OP_LH  = OPENUM_W'(2),
    parameter logic [OPENUM_W-1:0] OP_LW  = OPENUM_W'(3),
    parameter logic [OPENUM_W-1:0] OP_LBU = OPENUM_W'(4),
    parameter logic [OPENUM_W-1:0] OP_LHU = OPENUM_W'(5),
    parameter logic [OPENUM_W-1:0] OP_SB  = OPENUM_W'(6),
    parameter logic [OPENUM_W-1:0] OP_SH  = OPENUM_W'(7),
    parameter logic [OPENUM_W-1:0] OP_SW  = OPENUM_W'(8)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                enable_i,
    input  logic [OPENUM_W-1:0] openum_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         wdata_i,
    input  logic [ROB_ID_W-1:0] rob_id_i,
    output logic                busy_o,
    input  logic                misbranch_i,
    output logic                mem_valid_o,
    output logic                mem_we_o,
    output logic [31:0]         mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    output logic [1:0]          mem_len_o,
    input  logic                mem_done_i,
    input  logic [31:0]         mem_rdata_i,
    output logic                cdb_valid_o,
    output logic [ROB_ID_W-1:0] cdb_rob_id_o,
    output logic [31:0]         cdb_result_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state, state_next;
    logic                squash, squash_next;
    logic [OPENUM_W-1:0] op, op_next;
    logic [ROB_ID_W-1:0] rob_id, rob_id_next;

    logic                mem_valid_next, mem_we_next;
    logic [31:0]         mem_addr_next, mem_wdata_next;
    logic [1:0]          mem_len_next;
    logic                cdb_valid_next;
    logic [ROB_ID_W-1:0] cdb_rob_id_next;
    logic [31:0]         cdb_result_next;

    logic                issue_legal;
    logic                op_is_load;
    logic [1:0]          issue_len;
    logic [31:0]         load_result;

    // Loads and stores occupy one contiguous opcode range, loads first.
    assign issue_legal = (openum_i >= OP_LB) && (openum_i <= OP_SW);
    assign op_is_load  = (op >= OP_LB) && (op <= OP_LHU);

    // Counting enable_i as busy stops the LS buffer from issuing again in
    // the cycle after its strobe, before the state register has moved.
    assign busy_o = (state != S_IDLE) | enable_i;

    // Access size of the op being issued.
    always_comb begin
        issue_len = 2'b10;
        if (openum_i == OP_LB || openum_i == OP_LBU || openum_i == OP_SB)
            issue_len = 2'b00;
        else if (openum_i == OP_LH || openum_i == OP_LHU || openum_i == OP_SH)
            issue_len = 2'b01;
    end

    // Extension of returned read data according to the latched load opcode.
    always_comb begin
        load_result = mem_rdata_i;
        if (op == OP_LB)
            load_result = {{24{mem_rdata_i[7]}}, mem_rdata_i[7:0]};
        else if (op == OP_LBU)
            load_result = {24'h0, mem_rdata_i[7:0]};
        else if (op == OP_LH)
            load_result = {{16{mem_rdata_i[15]}}, mem_rdata_i[15:0]};
        else if (op == OP_LHU)
            load_result = {16'h0, mem_rdata_i[15:0]};
    end

    // Next-state and next-output logic. Everything holds by default; the CDB
    // strobe is dropped on any edge that does not complete a load.
    always_comb begin
        state_next      = state;
        squash_next     = squash;
        op_next         = op;
        rob_id_next     = rob_id;
        mem_valid_next  = mem_valid_o;
        mem_we_next     = mem_we_o;
        mem_addr_next   = mem_addr_o;
        mem_wdata_next  = mem_wdata_o;
        mem_len_next    = mem_len_o;
        cdb_valid_next  = 1'b0;
        cdb_rob_id_next = cdb_rob_id_o;
        cdb_result_next = cdb_result_o;

        case (state)
            S_IDLE: begin
                if (enable_i && !misbranch_i && issue_legal) begin
                    op_next        = openum_i;
                    rob_id_next    = rob_id_i;
                    squash_next    = 1'b0;
                    mem_valid_next = 1'b1;
                    mem_we_next    = (openum_i > OP_LHU);
                    mem_addr_next  = addr_i;
                    mem_wdata_next = wdata_i;
                    mem_len_next   = issue_len;
                    state_next     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done_i) begin
                    mem_valid_next = 1'b0;
                    squash_next    = 1'b0;
                    state_next     = S_IDLE;
                    // A flush on the completing edge squashes the load too.
                    if (op_is_load && !squash && !misbranch_i) begin
                        cdb_valid_next  = 1'b1;
                        cdb_rob_id_next = rob_id;
                        cdb_result_next = load_result;
                    end
                end else if (misbranch_i) begin
                    // The controller cannot abort, so the request keeps
                    // running and only the broadcast is suppressed.
                    squash_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State and output registers; reset wins over rdy, rdy low freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            squash       <= 1'b0;
            op           <= '0;
            rob_id       <= '0;
            mem_valid_o  <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= 32'h0;
            mem_wdata_o  <= 32'h0;
            mem_len_o    <= 2'b00;
            cdb_valid_o  <= 1'b0;
            cdb_rob_id_o <= '0;
            cdb_result_o <= 32'h0;
        end else if (rdy) begin
            state        <= state_next;
            squash       <= squash_next;
            op           <= op_next;
            rob_id       <= rob_id_next;
            mem_valid_o  <= mem_valid_next;
            mem_we_o     <= mem_we_next;
            mem_addr_o   <= mem_addr_next;
            mem_wdata_o  <= mem_wdata_next;
            mem_len_o    <= mem_len_next;
            cdb_valid_o  <= cdb_valid_next;
            cdb_rob_id_o <= cdb_rob_id_next;
            cdb_result_o <= cdb_result_next;
        end
    end

endmodule

// File: tb/tb_ls_unit.sv
// tb_ls_unit: directed self-checking bench for ls_unit.
//
// Inputs are driven 1 time unit after each rising edge and outputs are
// sampled at the same point, so every check sees the registers settled from
// the edge just taken.
module tb_ls_unit;

    localparam int OPENUM_W = 6;
    localparam int ROB_ID_W = 5;

    localparam logic [5:0] LB  = 6'd1;
    localparam logic [5:0] LH  = 6'd2;
    localparam logic [5:0] LW  = 6'd3;
    localparam logic [5:0] LBU = 6'd4;
    localparam logic [5:0] LHU = 6'd5;
    localparam logic [5:0] SB  = 6'd6;
    localparam logic [5:0] SW  = 6'd8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rdy = 1'b1;
    logic                enable_i = 1'b0;
    logic [OPENUM_W-1:0] openum_i = '0;
    logic [31:0]         addr_i = 32'h0;
    logic [31:0]         wdata_i = 32'h0;
    logic [ROB_ID_W-1:0] rob_id_i = '0;
    logic                busy_o;
    logic                misbranch_i = 1'b0;
    logic                mem_valid_o;
    logic                mem_we_o;
    logic [31:0]         mem_addr_o;
    logic [31:0]         mem_wdata_o;
    logic [1:0]          mem_len_o;
    logic                mem_done_i = 1'b0;
    logic [31:0]         mem_rdata_i = 32'h0;
    logic                cdb_valid_o;
    logic [ROB_ID_W-1:0] cdb_rob_id_o;
    logic [31:0]         cdb_result_o;

    int tests_run = 0;
    int tests_failed = 0;

    ls_unit dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .enable_i     (enable_i),
        .openum_i     (openum_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rob_id_i     (rob_id_i),
        .busy_o       (busy_o),
        .misbranch_i  (misbranch_i),
        .mem_valid_o  (mem_valid_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_len_o    (mem_len_o),
        .mem_done_i   (mem_done_i),
        .mem_rdata_i  (mem_rdata_i),
        .cdb_valid_o  (cdb_valid_o),
        .cdb_rob_id_o (cdb_rob_id_o),
        .cdb_result_o (cdb_result_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one op with a single-cycle strobe.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [4:0] rob);
        enable_i = 1'b1;
        openum_i = op;
        addr_i   = addr;
        wdata_i  = wdata;
        rob_id_i = rob;
        step();
        enable_i = 1'b0;
        openum_i = '0;
    endtask

    // One-cycle completion pulse from the controller.
    task automatic memDone(input logic [31:0] rdata);
        mem_done_i  = 1'b1;
        mem_rdata_i = rdata;
        step();
        mem_done_i  = 1'b0;
    endtask

    // Full load: issue, one idle WAIT cycle, done, check broadcast.
    task automatic loadCase(input string tag, input logic [5:0] op,
                            input logic [4:0] rob, input logic [31:0] rdata,
                            input logic [1:0] len, input logic [31:0] expected);
        applyStimulus(op, 32'h100, 32'h0, rob);
        checkOutput({tag, " len"}, {30'h0, mem_len_o}, {30'h0, len});
        step();
        memDone(rdata);
        checkOutput({tag, " cdb_valid"}, {31'h0, cdb_valid_o}, 32'h1);
        checkOutput({tag, " cdb_rob"}, {27'h0, cdb_rob_id_o}, {27'h0, rob});
        checkOutput({tag, " cdb_result"}, cdb_result_o, expected);
        step();
        checkOutput({tag, " cdb_pulse_end"}, {31'h0, cdb_valid_o}, 32'h0);
    endtask

    initial begin
        // Reset
        step();
        step();
        rst = 1'b0;
        checkOutput("reset mem_valid", {31'h0, mem_valid_o}, 32'h0);
        checkOutput("reset mem_addr", mem_addr_o, 32'h0);
        checkOutput("reset cdb_valid", {31'h0, cdb_valid_o}, 32'h0);
        checkOutput("reset busy", {31'h0, busy_o}, 32'h0);

        // LB with a two-cycle controller latency
        enable_i = 1'b1;
        openum_i = LB;
        #0;
        checkOutput("busy on strobe", {31'h0, busy_o}, 32'h1);
        applyStimulus(LB, 32'h100, 32'h0, 5'd3);
        checkOutput("lb mem_valid", {31'h0, mem_valid_o}, 32'h1);
        checkOutput("lb mem_addr", mem_addr_o, 32'h100);
        checkOutput("lb mem_we", {31'h0, mem_we_o}, 32'h0);
        checkOutput("lb mem_len", {30'h0, mem_len_o}, 32'h0);
        step();
        checkOutput("lb wait mem_valid", {31'h0, mem_valid_o}, 32'h1);
        checkOutput("lb wait cdb", {31'h0, cdb_valid_o}, 32'h0);
        memDone(32'h000000F0);
        checkOutput("lb cdb_valid", {31'h0, cdb_valid_o}, 32'h1);
        checkOutput("lb cdb_rob", {27'h0, cdb_rob_id_o}, 32'd3);
        checkOutput("lb cdb_result", cdb_result_o, 32'hFFFFFFF0);
        checkOutput("lb done mem_valid", {31'h0, mem_valid_o}, 32'h0);
        checkOutput("lb done busy", {31'h0, busy_o}, 32'h0);
        step();
        checkOutput("lb pulse end", {31'h0, cdb_valid_o}, 32'h0);

        // Remaining load flavours
        loadCase("lbu", LBU, 5'd4, 32'h000000F0, 2'b00, 32'h000000F0);
        loadCase("lhu", LHU, 5'd5, 32'h1234ABCD, 2'b01, 32'h0000ABCD);
        loadCase("lh",  LH,  5'd6, 32'h00008001, 2'b01, 32'hFFFF8001);
        loadCase("lw",  LW,  5'd8, 32'hCAFEBABE, 2'b10, 32'hCAFEBABE);

        // SW: write request held stable, no broadcast
        applyStimulus(SW, 32'h200, 32'hDEADBEEF, 5'd7);
        checkOutput("sw mem_we", {31'h0, mem_we_o}, 32'h1);
        checkOutput("sw mem_len", {30'h0, mem_len_o}, 32'h2);
        checkOutput("sw mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        step();
        step();
        checkOutput("sw held addr", mem_addr_o, 32'h200);
        checkOutput("sw held valid", {31'h0, mem_valid_o}, 32'h1);
        checkOutput("sw held wdata", mem_wdata_o, 32'hDEADBEEF);
        memDone(32'h0);
        checkOutput("sw no cdb", {31'h0, cdb_valid_o}, 32'h0);
        checkOutput("sw done valid", {31'h0, mem_valid_o}, 32'h0);
        checkOutput("sw done busy", {31'h0, busy_o}, 32'h0);

        // Second strobe while busy is not accepted
        applyStimulus(LW, 32'h400, 32'h0, 5'd9);
        enable_i = 1'b1;
        openum_i = SB;
        addr_i   = 32'h999;
        #0;
        checkOutput("busy wait", {31'h0, busy_o}, 32'h1);
        step();
        enable_i = 1'b0;
        openum_i = '0;
        checkOutput("busy addr kept", mem_addr_o, 32'h400);
        checkOutput("busy we kept", {31'h0, mem_we_o}, 32'h0);
        checkOutput("busy still", {31'h0, busy_o}, 32'h1);
        memDone(32'h11223344);
        checkOutput("busy cdb_rob", {27'h0, cdb_rob_id_o}, 32'd9);
        checkOutput("busy cdb_result", cdb_result_o, 32'h11223344);
        step();
        checkOutput("busy no 2nd req", {31'h0, mem_valid_o}, 32'h0);

        // Misbranch during WAIT squashes the load
        applyStimulus(LW, 32'h500, 32'h0, 5'd10);
        step();
        misbranch_i = 1'b1;
        step();
        misbranch_i = 1'b0;
        checkOutput("mb held valid", {31'h0, mem_valid_o}, 32'h1);
        memDone(32'h55555555);
        checkOutput("mb no cdb", {31'h0, cdb_valid_o}, 32'h0);
        checkOutput("mb idle busy", {31'h0, busy_o}, 32'h0);
        loadCase("post-mb lb", LB, 5'd11, 32'h0000007F, 2'b00, 32'h0000007F);

        // Done and misbranch on the same edge
        applyStimulus(LW, 32'h600, 32'h0, 5'd12);
        misbranch_i = 1'b1;
        memDone(32'h12345678);
        misbranch_i = 1'b0;
        checkOutput("done+mb no cdb", {31'h0, cdb_valid_o}, 32'h0);
        checkOutput("done+mb valid", {31'h0, mem_valid_o}, 32'h0);

        // Dropped issues and stray done
        applyStimulus(6'd0, 32'h700, 32'h0, 5'd1);
        checkOutput("op0 dropped", {31'h0, mem_valid_o}, 32'h0);
        applyStimulus(6'd9, 32'h700, 32'h0, 5'd1);
        checkOutput("op9 dropped", {31'h0, mem_valid_o}, 32'h0);
        misbranch_i = 1'b1;
        applyStimulus(LW, 32'h700, 32'h0, 5'd1);
        misbranch_i = 1'b0;
        checkOutput("mb issue dropped", {31'h0, mem_valid_o}, 32'h0);
        memDone(32'hFFFFFFFF);
        checkOutput("idle done cdb", {31'h0, cdb_valid_o}, 32'h0);

        // rdy low freezes the unit, including a done pulse
        applyStimulus(LH, 32'h800, 32'h0, 5'd13);
        rdy = 1'b0;
        memDone(32'h00000080);
        checkOutput("rdy0 valid", {31'h0, mem_valid_o}, 32'h1);
        checkOutput("rdy0 cdb", {31'h0, cdb_valid_o}, 32'h0);
        checkOutput("rdy0 busy", {31'h0, busy_o}, 32'h1);
        rdy = 1'b1;
        step();
        checkOutput("rdy1 still wait", {31'h0, mem_valid_o}, 32'h1);
        memDone(32'h00000080);
        checkOutput("rdy lh result", cdb_result_o, 32'h00000080);
        checkOutput("rdy lh rob", {27'h0, cdb_rob_id_o}, 32'd13);
        rdy = 1'b0;
        step();
        checkOutput("rdy0 cdb held", {31'h0, cdb_valid_o}, 32'h1);
        rdy = 1'b1;
        step();
        checkOutput("rdy1 cdb clear", {31'h0, cdb_valid_o}, 32'h0);

        // Reset mid-WAIT overrides rdy; later done is ignored
        applyStimulus(SW, 32'h300, 32'h1, 5'd14);
        rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        rdy = 1'b1;
        checkOutput("rst valid", {31'h0, mem_valid_o}, 32'h0);
        checkOutput("rst we", {31'h0, mem_we_o}, 32'h0);
        checkOutput("rst addr", mem_addr_o, 32'h0);
        checkOutput("rst wdata", mem_wdata_o, 32'h0);
        checkOutput("rst len", {30'h0, mem_len_o}, 32'h0);
        checkOutput("rst busy", {31'h0, busy_o}, 32'h0);
        memDone(32'h0BADF00D);
        checkOutput("rst late done cdb", {31'h0, cdb_valid_o}, 32'h0);
        checkOutput("rst late done valid", {31'h0, mem_valid_o}, 32'h0);
        loadCase("post-rst lw", LW, 5'd15, 32'h87654321, 2'b10, 32'h87654321);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
